// File: rtl/par_ser_pkg.sv
// par_ser_pkg: shared types, default sizes and the WIDTH clamp helper for
// the par_ser serializer. Used by par_ser (optional feature macro:
// PAR_SER_PARITY_EN).
package par_ser_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int MAX_WIDTH_C = 512;
    localparam int CNT_W_C     = 10;

    // Requested bit counts above the datapath width are silently limited to it.
    function automatic int unsigned clamp_width(input int unsigned w,
                                                input int unsigned maxw);
        return (w > maxw) ? maxw : w;
    endfunction

endpackage

// File: rtl/par_reg.sv
// par_reg: parallel word register with load enable. Its op bus is the
// parallel source that par_ser serializes.
module par_reg #(
    parameter int W = 512
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] ip,
    output logic [W-1:0] op
);

    // Capture ip whenever en is high; clear on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op <= '0;
        end else if (en) begin
            op <= ip;
        end
    end

endmodule

// File: rtl/par_ser.sv
// par_ser: parallel-in, serial-out transmitter. Loads a word and a runtime
// bit count over a valid/ready handshake and sends it LSB-first with
// valid/ready backpressure on the serial side.
// Optional feature macro: PAR_SER_PARITY_EN appends one even-parity beat.
module par_ser
    import par_ser_pkg::*;
#(
    parameter int MAX_WIDTH = MAX_WIDTH_C,
    parameter int CNT_W     = CNT_W_C
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [CNT_W-1:0]     WIDTH,
    input  logic [MAX_WIDTH-1:0] ip,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 sout,
    output logic                 sout_valid,
    output logic                 sout_last,
    input  logic                 out_ready,
    output logic                 load_err
);

`ifdef PAR_SER_PARITY_EN
    // One extra slot above the data holds the parity bit.
    localparam int SH_W = MAX_WIDTH + 1;
`else
    localparam int SH_W = MAX_WIDTH;
`endif

    state_t           state;
    logic [SH_W-1:0]  shreg;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic [CNT_W-1:0] wclamp;
    logic [SH_W-1:0]  load_word;
    logic [CNT_W-1:0] load_cnt;

    assign wclamp = CNT_W'(clamp_width(32'(WIDTH), 32'(MAX_WIDTH)));

    assign sout_valid = (state == ST_SHIFT);
    assign sout       = (state == ST_SHIFT) && shreg[0];
    assign sout_last  = (state == ST_SHIFT) && (cnt == '0);
    // Ready while idle, or on the final accepted beat so frames run back-to-back.
    assign in_ready   = reset && ((state == ST_IDLE) || (sout_last && out_ready));
    assign load       = in_valid && in_ready;

`ifdef PAR_SER_PARITY_EN
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] masked;
    logic                 par;

    // Mask off unsent bits, then place the parity bit just above the data.
    always_comb begin
        mask      = {MAX_WIDTH{1'b1}} >> (32'(MAX_WIDTH) - 32'(wclamp));
        masked    = ip & mask;
        par       = ^masked;
        load_word = SH_W'(masked) | (SH_W'(par) << wclamp);
        load_cnt  = wclamp;
    end
`else
    // Upper bits never reach sout because the counter ends the frame first.
    always_comb begin
        load_word = ip;
        load_cnt  = wclamp - 1'b1;
    end
`endif

    // FSM, shift register, bit counter and error pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            cnt      <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= load && (wclamp == '0);
            if (load && (wclamp != '0)) begin
                shreg <= load_word;
                cnt   <= load_cnt;
                state <= ST_SHIFT;
            end else if (load) begin
                // Zero-length word is dropped; any running frame has just ended.
                state <= ST_IDLE;
            end else if ((state == ST_SHIFT) && out_ready) begin
                shreg <= shreg >> 1;
                if (cnt == '0) begin
                    state <= ST_IDLE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_par_ser.sv
// tb_par_ser: directed self-checking bench for par_ser, with par_reg
// feeding it for the integration case.
module tb_par_ser;
    import par_ser_pkg::*;

    localparam int MW = 512;
    localparam int CW = 10;
`ifdef PAR_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic          clock;
    logic          reset;
    logic [CW-1:0] WIDTH;
    logic [MW-1:0] ip_drv;
    logic [MW-1:0] ip_dut;
    logic          in_valid;
    logic          in_ready;
    logic          sout;
    logic          sout_valid;
    logic          sout_last;
    logic          out_ready;
    logic          load_err;
    logic          en;
    logic [MW-1:0] reg_ip;
    logic [MW-1:0] reg_op;
    logic          use_reg;

    int errors = 0;
    int checks = 0;

    par_reg #(.W(MW)) u_reg (
        .clock (clock),
        .reset (reset),
        .en    (en),
        .ip    (reg_ip),
        .op    (reg_op)
    );

    assign ip_dut = use_reg ? reg_op : ip_drv;

    par_ser #(.MAX_WIDTH(MW), .CNT_W(CW)) dut (
        .clock      (clock),
        .reset      (reset),
        .WIDTH      (WIDTH),
        .ip         (ip_dut),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last),
        .out_ready  (out_ready),
        .load_err   (load_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load one frame with out_ready high and check every beat.
    task automatic recv_frame(input string tag, input logic [CW-1:0] wdrv,
                              input int weff, input logic [MW-1:0] data);
        logic par;
        logic ebit;
        int   nb;
        par = 1'b0;
        for (int i = 0; i < weff; i++) par ^= data[i];
        nb = weff + PAR;
        WIDTH     = wdrv;
        ip_drv    = data;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, " in_ready@load"}, 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        WIDTH    = '1;
        ip_drv   = '1;
        for (int b = 0; b < nb; b++) begin
            ebit = (b < weff) ? data[b] : par;
            #1;
            chk($sformatf("%s valid b%0d", tag, b), 32'(sout_valid), 32'd1);
            chk($sformatf("%s sout b%0d", tag, b), 32'(sout), 32'(ebit));
            chk($sformatf("%s last b%0d", tag, b), 32'(sout_last), 32'(b == nb - 1));
            tick;
        end
        #1;
        chk({tag, " idle after"}, 32'(sout_valid), 32'd0);
        chk({tag, " ready after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [5:0] t3bits;
        logic [5:0] t3last;
        int         idxa;
        int         nb;
        int         b;
        logic [4:0] t2pat;

        reset     = 1'b0;
        in_valid  = 1'b0;
        WIDTH     = '0;
        ip_drv    = '0;
        out_ready = 1'b0;
        en        = 1'b0;
        reg_ip    = '0;
        use_reg   = 1'b0;

        // Reset state
        repeat (2) tick;
        chk("rst sout", 32'(sout), 32'd0);
        chk("rst sout_valid", 32'(sout_valid), 32'd0);
        chk("rst sout_last", 32'(sout_last), 32'd0);
        chk("rst load_err", 32'(load_err), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("post-rst in_ready", 32'(in_ready), 32'd1);
        chk("post-rst sout_valid", 32'(sout_valid), 32'd0);
        tick;

        // Basic frame: 0x0B, 4 bits -> 1,1,0,1 (+ parity 1)
        recv_frame("t1", CW'(4), 4, MW'(32'h0B));

        // Stalls: 3 bits of 0x1FF with out_ready 1,0,0,1,1
        t2pat     = 5'b11001;
        WIDTH     = CW'(3);
        ip_drv    = MW'(32'h1FF);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        b = 0;
        for (int c = 0; c < 5 + PAR; c++) begin
            out_ready = (c < 5) ? t2pat[c] : 1'b1;
            if (!out_ready) begin
                WIDTH  = CW'(7);
                ip_drv = '0;
            end
            #1;
            chk($sformatf("t2 valid c%0d", c), 32'(sout_valid), 32'd1);
            chk($sformatf("t2 sout c%0d", c), 32'(sout), 32'd1);
            chk($sformatf("t2 last c%0d", c), 32'(sout_last), 32'(b == 2 + PAR));
            chk($sformatf("t2 in_ready c%0d", c), 32'(in_ready),
                32'((b == 2 + PAR) && out_ready));
            tick;
            if (out_ready) b++;
        end
        #1;
        chk("t2 idle after", 32'(sout_valid), 32'd0);

        // Back-to-back frames: W=2 ip=2, then W=2 ip=1
`ifdef PAR_SER_PARITY_EN
        t3bits = 6'b101110;
        t3last = 6'b100100;
`else
        t3bits = 6'b000110;
        t3last = 6'b001010;
`endif
        idxa      = 1 + PAR;
        nb        = 4 + 2 * PAR;
        WIDTH     = CW'(2);
        ip_drv    = MW'(2);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < nb; k++) begin
            in_valid = (k == idxa);
            WIDTH    = CW'(2);
            ip_drv   = MW'(1);
            #1;
            chk($sformatf("t3 valid b%0d", k), 32'(sout_valid), 32'd1);
            chk($sformatf("t3 sout b%0d", k), 32'(sout), 32'(t3bits[k]));
            chk($sformatf("t3 last b%0d", k), 32'(sout_last), 32'(t3last[k]));
            chk($sformatf("t3 in_ready b%0d", k), 32'(in_ready), 32'(t3last[k]));
            tick;
            in_valid = 1'b0;
        end
        #1;
        chk("t3 idle after", 32'(sout_valid), 32'd0);

        // Zero-width load
        WIDTH    = '0;
        ip_drv   = MW'(32'hFF);
        in_valid = 1'b1;
        #1;
        chk("t4 in_ready@load", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        #1;
        chk("t4 load_err", 32'(load_err), 32'd1);
        chk("t4 sout_valid", 32'(sout_valid), 32'd0);
        chk("t4 in_ready", 32'(in_ready), 32'd1);
        tick;
        chk("t4 load_err clear", 32'(load_err), 32'd0);
        chk("t4 still idle", 32'(sout_valid), 32'd0);

        // Clamp: WIDTH=600, walking one at bit 511
        recv_frame("t5", CW'(600), 512, {1'b1, 511'b0});

        // Reset mid-frame at beat 5 of a 16-bit frame
        WIDTH     = CW'(16);
        ip_drv    = MW'(32'hA5C3);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t6 sout b%0d", k), 32'(sout), 32'((32'hA5C3 >> k) & 1));
            chk($sformatf("t6 valid b%0d", k), 32'(sout_valid), 32'd1);
            tick;
        end
        #2;
        reset = 1'b0;
        #1;
        chk("t6 rst sout_valid", 32'(sout_valid), 32'd0);
        chk("t6 rst sout", 32'(sout), 32'd0);
        chk("t6 rst sout_last", 32'(sout_last), 32'd0);
        chk("t6 rst in_ready", 32'(in_ready), 32'd0);
        tick;
        chk("t6 held valid", 32'(sout_valid), 32'd0);
        reset = 1'b1;
        #1;
        chk("t6 release in_ready", 32'(in_ready), 32'd1);
        chk("t6 release valid", 32'(sout_valid), 32'd0);
        tick;
        chk("t6 no resume", 32'(sout_valid), 32'd0);
        recv_frame("t6f", CW'(16), 16, MW'(32'h1234));

        // Integration: par_reg holds the word, par_ser sends 3 bits of 6
        reg_ip = MW'(32'h6);
        en     = 1'b1;
        tick;
        en      = 1'b0;
        reg_ip  = '0;
        use_reg = 1'b1;
        recv_frame("t7", CW'(3), 3, MW'(32'h6));
        use_reg = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
